// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output capture path.
// Defaults match the production filter configuration.
package fir_pkg;

  localparam int DATA_BIT_NUM = 16;
  localparam int DELAY_NUM    = 64;
  localparam int SAMPLES      = 1024;
  localparam int OUT_W        = 2 * DATA_BIT_NUM;
  localparam int ADDR_W       = $clog2(SAMPLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sample_ram.sv
// Single-port synchronous buffer RAM with a registered read port.
// A cycle is either a write or a read, never both.
module sample_ram
  import fir_pkg::*;
#(
  parameter int WORD_W = OUT_W,
  parameter int DEPTH  = SAMPLES
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/fir_sample_capture.sv
// Captures one filter output word per sample period into a buffer,
// then drains the buffer over a valid/ready stream in index order.
module fir_sample_capture
  import fir_pkg::*;
#(
  parameter int DATA_BIT_NUM = fir_pkg::DATA_BIT_NUM,
  parameter int DELAY_NUM    = fir_pkg::DELAY_NUM,
  parameter int SAMPLES      = fir_pkg::SAMPLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic signed [2*DATA_BIT_NUM-1:0]  filter_data_out,
  output logic                              cap_busy,
  output logic                              cap_done,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic signed [2*DATA_BIT_NUM-1:0]  rd_data,
  output logic [$clog2(SAMPLES)-1:0]        rd_index,
  output logic                              rd_last
);

  localparam int WORD_W = 2 * DATA_BIT_NUM;
  localparam int ADR_W  = $clog2(SAMPLES);
  localparam int CNT_W  = (DELAY_NUM > 0) ? $clog2(DELAY_NUM + 1) : 1;
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(DELAY_NUM);
  localparam logic [ADR_W-1:0] ADDR_LAST   = ADR_W'(SAMPLES - 1);
  localparam logic [ADR_W:0]   READ_TOTAL  = (ADR_W + 1)'(SAMPLES);

  cap_state_e state_reg, state_next;

  logic [CNT_W-1:0]  period_reg;
  logic [ADR_W-1:0]  wr_ptr_reg;
  logic [ADR_W:0]    rd_ptr_reg;
  logic [ADR_W-1:0]  ld_cnt_reg;
  logic              ram_vld_reg;
  logic              out_vld_reg;
  logic              skid_vld_reg;
  logic [WORD_W-1:0] out_data_reg;
  logic [WORD_W-1:0] skid_data_reg;
  logic [ADR_W-1:0]  out_idx_reg;

  logic              capturing, draining, arm;
  logic              cap_tick, rd_en, pop, last_pop, out_load;
  logic [1:0]        occupancy;
  logic [ADR_W-1:0]  ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: if (cap_tick && wr_ptr_reg == ADDR_LAST) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = DONE;
      DONE:    if (start) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capturing = 1'b0;
    draining  = 1'b0;
    cap_busy  = 1'b0;
    cap_done  = 1'b0;
    case (state_reg)
      CAPTURE: begin
        capturing = 1'b1;
        cap_busy  = 1'b1;
      end
      DRAIN: begin
        draining = 1'b1;
        cap_busy = 1'b1;
      end
      DONE:    cap_done = 1'b1;
      default: ;
    endcase
  end

  // A read is only issued when the skid pair will have room for its data.
  always_comb begin
    arm       = start && (state_reg == IDLE || state_reg == DONE);
    cap_tick  = capturing && (period_reg == PERIOD_LAST);
    pop       = draining && out_vld_reg && rd_ready;
    last_pop  = pop && (out_idx_reg == ADDR_LAST);
    occupancy = 2'(out_vld_reg) + 2'(skid_vld_reg) + 2'(ram_vld_reg) - 2'(pop);
    rd_en     = draining && (rd_ptr_reg < READ_TOTAL) && (occupancy < 2'd2);
    out_load  = !out_vld_reg || pop;
    ram_addr  = capturing ? wr_ptr_reg : rd_ptr_reg[ADR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      period_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (capturing) begin
        period_reg <= cap_tick ? '0 : period_reg + CNT_W'(1);
      end
      if (cap_tick) begin
        wr_ptr_reg <= wr_ptr_reg + ADR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + (ADR_W + 1)'(1);
      end
    end
  end

  sample_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (SAMPLES)
  ) u_ram (
    .clk   (clk),
    .en    (cap_tick || rd_en),
    .we    (cap_tick),
    .addr  (ram_addr),
    .wdata (filter_data_out),
    .rdata (ram_rdata)
  );

  // Output register refills from the skid entry first, then straight from RAM.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      ram_vld_reg   <= 1'b0;
      out_vld_reg   <= 1'b0;
      skid_vld_reg  <= 1'b0;
      out_data_reg  <= '0;
      skid_data_reg <= '0;
      out_idx_reg   <= '0;
      ld_cnt_reg    <= '0;
    end else begin
      ram_vld_reg <= rd_en;
      if (out_load) begin
        if (skid_vld_reg) begin
          out_vld_reg   <= 1'b1;
          out_data_reg  <= skid_data_reg;
          out_idx_reg   <= ld_cnt_reg;
          ld_cnt_reg    <= ld_cnt_reg + ADR_W'(1);
          skid_vld_reg  <= ram_vld_reg;
          skid_data_reg <= ram_rdata;
        end else if (ram_vld_reg) begin
          out_vld_reg  <= 1'b1;
          out_data_reg <= ram_rdata;
          out_idx_reg  <= ld_cnt_reg;
          ld_cnt_reg   <= ld_cnt_reg + ADR_W'(1);
        end else begin
          out_vld_reg <= 1'b0;
        end
      end else if (ram_vld_reg) begin
        skid_vld_reg  <= 1'b1;
        skid_data_reg <= ram_rdata;
      end
    end
  end

  assign rd_valid = out_vld_reg;
  assign rd_data  = out_data_reg;
  assign rd_index = out_idx_reg;
  assign rd_last  = out_vld_reg && (out_idx_reg == ADDR_LAST);

endmodule
